mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  Pipelined MEM stage. Takes execute_data_t from EX, and for loads/stores runs a
//  data-bus transaction with byte strobes, load sign/zero extension and a misalign
//  check. It presents memory_data_t to WB with a valid/ready handshake.
//  Sits between the EX/MEM and MEM/WB boundaries. Stalls the pipe via in_ready
//  while a bus access is outstanding.
// PARAMETERS
//  XLEN      64  datapath/register width (32 or 64; LD/SD/LWU illegal when 32)
//  ADDR_W    64  data-bus address width
//  CHECK_ALN 1   1: misaligned access raises misalign, no bus request; 0: issue anyway
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-low
//  flush          in   1        kill current instr (mispredict/trap); see BEHAVIOUR
//  in_valid       in   1        dataE valid
//  in_ready       out  1        stage can accept dataE this cycle
//  dataE          in   $bits(execute_data_t)  pc, raw_instr, ctl(mem_rd,mem_wr,msize,munsigned), dst, alu_out(=addr), wdata
//  out_valid      out  1        dataM valid
//  out_ready      in   1        WB accepts dataM
//  dataM          out  $bits(memory_data_t)  pc, raw_instr, ctl, dst, alu_out, mem_rdata(XLEN), misalign
//  dreq_valid     out  1        bus request valid
//  dreq_addr      out  ADDR_W   byte address
//  dreq_size      out  3        msize_t (MSIZE1/2/4/8)
//  dreq_strobe    out  XLEN/8   byte write enables; 0 = read
//  dreq_data      out  XLEN     store data, lane-shifted
//  dresp_addr_ok  in   1        request accepted
//  dresp_data_ok  in   1        response/ack complete
//  dresp_data     in   XLEN     raw read data (full bus word)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, out_valid=0, dataM=0, dreq_valid=0, dreq_*=0.
//   - in_ready becomes 1 the first cycle after reset releases.
//  in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Transfers:
//   - Accept on in_valid&&in_ready.
//   - Output transfer on out_valid&&out_ready.
//   - dataM must be stable while out_valid && !out_ready.
//  Non-memory instr: dataM <= dataE fields (mem_rdata=0) at accept edge; out_valid=1 next cycle.
//   Throughput 1/cycle.
//  FSM IDLE/REQ/WAIT/DRAIN:
//   - IDLE->REQ: on accept of a load/store that passes the align check. Latch dataE in the hold reg.
//   - REQ: dreq_valid=1; addr/size/strobe/data constant until addr_ok.
//     - addr_ok && data_ok in the same cycle -> complete.
//     - addr_ok alone -> WAIT.
//   - WAIT: dreq_valid=0; on data_ok -> complete.
//   - Complete: load dataM, out_valid=1, go to IDLE. Earliest result is 1 cycle after the REQ entry edge.
//  Alignment:
//   - Misaligned when addr mod size != 0.
//   - With CHECK_ALN=1: no bus access, dataM.misalign=1, out next cycle like a non-mem instr.
//  Store lanes (off = addr[log2(XLEN/8)-1:0]):
//   - strobe = ((1<<size)-1)<<off.
//   - dreq_data = wdata<<(8*off), with wdata replicated low bytes.
//  Load:
//   - sel = dresp_data>>(8*off), truncated to size.
//   - Sign-extend unless munsigned; XLEN=64 LW sign-extends bit31.
//  Flush:
//   - IDLE: drop pending output (out_valid<=0).
//   - REQ before addr_ok: deassert dreq_valid next cycle -> IDLE. Valid-then-drop is allowed by the bus.
//   - REQ on the addr_ok cycle, or WAIT: -> DRAIN. Wait for data_ok, discard it, -> IDLE.
//     A store already accepted by the bus is NOT undone.
//   - in_ready=0 throughout DRAIN.
//  Simultaneous events:
//   - flush wins over accept.
//   - out_ready and completion in the same cycle: the new result replaces the old.
//   - Reset mid-transaction abandons the bus. The bus side is reset in the same domain.
// STRUCTURE
//  pipes package: memory_data_t gains mem_rdata and misalign; ctl gains munsigned.
//  common package: msize_t, MSIZE1..MSIZE8.
//  Sub-module mem_lane_align (combinational): strobe/data shift for stores; extract/extend for loads.
//  Top holds the FSM, hold register and output register.
// TESTING (XLEN=64, CHECK_ALN=1)
//  1. 3 back-to-back ALU instrs, out_ready=1:
//     in_ready stays 1; dataM appears on cycles 1,2,3 in order.
//  2. LB addr=0x1003, dresp_data=0x00000000_80000000 (byte3=0x80), addr_ok+data_ok same cycle:
//     mem_rdata=0xFFFF_FFFF_FFFF_FF80.
//     Same with LBU: mem_rdata=0x80.
//  3. SH addr=0x2006, wdata=0xBEEF:
//     strobe=8'hC0, dreq_data[63:48]=0xBEEF.
//     dreq_valid held 4 cycles until addr_ok; data_ok 3 cycles later; in_ready=0 throughout.
//  4. LW addr=0x3002: no dreq_valid, dataM.misalign=1, out_valid next cycle.
//  5. Load accepted by bus (addr_ok), flush in WAIT, data_ok 5 cycles later:
//     - FSM in DRAIN; out_valid never rises for that load.
//     - Next instr accepted the cycle after data_ok.
//  6. out_ready=0 for 6 cycles after a completed LD: dataM stable, in_ready=0.
//     reset=0 mid-WAIT: all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared types, widths and helpers for the MEM pipeline stage
package mem_stage_ctrl_pkg;
    localparam int XLEN = 64;
    localparam int ADDR_W = 64;
    localparam int OFF_W = $clog2(XLEN / 8);
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        msize_t msize;
        logic munsigned;
    } ctl_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0] raw_instr;
        ctl_t ctl;
        logic [4:0] dst;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] wdata;
    } execute_data_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0] raw_instr;
        ctl_t ctl;
        logic [4:0] dst;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] mem_rdata;
        logic misalign;
    } memory_data_t;
    function automatic logic misaligned(logic [OFF_W-1:0] off, msize_t s);
        return (off & OFF_W'((4'd1 << s) - 4'd1)) != '0;
    endfunction
    function automatic memory_data_t mk_mem(execute_data_t e, logic [XLEN-1:0] rdata, logic mis);
        return '{pc: e.pc, raw_instr: e.raw_instr, ctl: e.ctl, dst: e.dst, alu_out: e.alu_out,
                 mem_rdata: rdata, misalign: mis};
    endfunction
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: EX/WB handshakes and data-bus signals of the MEM stage
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;
    logic flush;
    logic in_valid;
    logic in_ready;
    execute_data_t dataE;
    logic out_valid;
    logic out_ready;
    memory_data_t dataM;
    logic dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    msize_t dreq_size;
    logic [XLEN/8-1:0] dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic dresp_addr_ok;
    logic dresp_data_ok;
    logic [XLEN-1:0] dresp_data;
    modport slave (
        input flush, in_valid, dataE, out_ready, dresp_addr_ok, dresp_data_ok, dresp_data,
        output in_ready, out_valid, dataM, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );
    modport master (
        output flush, in_valid, dataE, out_ready, dresp_addr_ok, dresp_data_ok, dresp_data,
        input in_ready, out_valid, dataM, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );
endinterface

// File: rtl/mem_stage_ctrl_lane_align.sv
// mem_lane_align: store strobe/lane shift and load extract/extend for one bus word
module mem_lane_align
    import mem_stage_ctrl_pkg::*;
(
    input  logic [OFF_W-1:0] off,
    input  msize_t size,
    input  logic munsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN/8-1:0] strobe,
    output logic [XLEN-1:0] sdata,
    output logic [XLEN-1:0] ldata
);
    logic [XLEN/8:0] mask;
    logic [XLEN-1:0] rep;
    logic [XLEN-1:0] sel;
    logic sx;
    assign mask = (9'd1 << (4'd1 << size)) - 9'd1;
    assign strobe = mask[XLEN/8-1:0] << off;
    assign rep = size == MSIZE1 ? {8{wdata[7:0]}}
               : size == MSIZE2 ? {4{wdata[15:0]}}
               : size == MSIZE4 ? {2{wdata[31:0]}} : wdata;
    assign sdata = rep << {off, 3'b000};
    assign sel = rdata >> {off, 3'b000};
    assign sx = ~munsigned;
    assign ldata = size == MSIZE1 ? {{56{sx & sel[7]}}, sel[7:0]}
                 : size == MSIZE2 ? {{48{sx & sel[15]}}, sel[15:0]}
                 : size == MSIZE4 ? {{32{sx & sel[31]}}, sel[31:0]} : sel;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage with data-bus FSM, hold register and WB output register
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter bit CHECK_ALN = 1'b1
) (
    input logic clk,
    input logic reset,
    mem_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state;
    execute_data_t hold;
    memory_data_t data_m;
    logic out_valid;
    logic accept, is_mem, mis, go_req, req, done;
    logic [XLEN/8-1:0] strobe;
    logic [XLEN-1:0] sdata, ldata;
    mem_lane_align u_align (
        .off(hold.alu_out[OFF_W-1:0]),
        .size(hold.ctl.msize),
        .munsigned(hold.ctl.munsigned),
        .wdata(hold.wdata),
        .rdata(bus.dresp_data),
        .strobe(strobe),
        .sdata(sdata),
        .ldata(ldata)
    );
    assign bus.in_ready = reset && state == IDLE && (!out_valid || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign is_mem = bus.dataE.ctl.mem_rd || bus.dataE.ctl.mem_wr;
    assign mis = CHECK_ALN && is_mem && misaligned(bus.dataE.alu_out[OFF_W-1:0], bus.dataE.ctl.msize);
    assign go_req = accept && is_mem && !mis;
    assign req = state == REQ;
    // A flushed access still completes on the bus; only its result is dropped.
    assign done = bus.dresp_data_ok && !bus.flush && (state == WAIT || (req && bus.dresp_addr_ok));
    assign bus.out_valid = out_valid;
    assign bus.dataM = data_m;
    assign bus.dreq_valid = req;
    assign bus.dreq_addr = req ? hold.alu_out : '0;
    assign bus.dreq_size = req ? hold.ctl.msize : MSIZE1;
    assign bus.dreq_strobe = req && hold.ctl.mem_wr ? strobe : '0;
    assign bus.dreq_data = req && hold.ctl.mem_wr ? sdata : '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            out_valid <= 1'b0;
            data_m <= '0;
            hold <= '0;
        end else begin
            if (bus.out_ready || (state == IDLE && bus.flush)) out_valid <= 1'b0;
            if (accept && !go_req) begin
                data_m <= mk_mem(bus.dataE, '0, mis);
                out_valid <= 1'b1;
            end
            if (done) begin
                data_m <= mk_mem(hold, hold.ctl.mem_rd ? ldata : '0, 1'b0);
                out_valid <= 1'b1;
            end
            case (state)
                IDLE: if (go_req) begin
                    hold <= bus.dataE;
                    state <= REQ;
                end
                REQ: state <= bus.dresp_addr_ok ? (bus.dresp_data_ok ? IDLE : bus.flush ? DRAIN : WAIT)
                                                : bus.flush ? IDLE : REQ;
                WAIT: state <= bus.dresp_data_ok ? IDLE : bus.flush ? DRAIN : WAIT;
                DRAIN: state <= bus.dresp_data_ok ? IDLE : DRAIN;
            endcase
        end
    end
endmodule
